// File: rtl/chroma_mod.sv
// chroma_mod: composite-video chroma modulator clocked at 16x the colour
// subcarrier. A free-running phase accumulator and a 16-entry sine table
// produce one subcarrier cycle every 16 clocks. Each sample is resolved
// against sync, burst, blank and active video, in that order of priority.
// The result reaches luma_out, chroma_out and burst_active on the second
// clock after the inputs were captured. Three register levels hold the
// sample (capture, table lookup, amplitude scaling).

module chroma_mod #(
    parameter logic [5:0] BLANK_LEVEL     = 6'd18,
    parameter logic [2:0] BURST_AMP       = 3'b010,
    parameter int         NTSC_BURST_CLKS = 144,
    parameter int         PAL_BURST_CLKS  = 160
) (
    input  logic       clk_col16x,
    input  logic       rst,
    input  logic [5:0] luma_in,
    input  logic [2:0] amplitude_in,
    input  logic [7:0] phase_in,
    input  logic       is_pal,
    input  logic       oddline,
    input  logic       sync,
    input  logic       blank,
    input  logic       burst_start,
    output logic [5:0] luma_out,
    output logic [5:0] chroma_out,
    output logic       burst_active
);

    localparam int MAX_BURST_CLKS = (NTSC_BURST_CLKS > PAL_BURST_CLKS) ?
                                    NTSC_BURST_CLKS : PAL_BURST_CLKS;
    localparam int BCNT_W = $clog2(MAX_BURST_CLKS + 1);

    // Phase step per clock: 256 units per subcarrier cycle / 16 clocks.
    localparam logic [7:0] ACC_STEP    = 8'd16;

    // Burst phases in 256-per-turn units: 180, 135 and 225 degrees.
    localparam logic [7:0] PH_NTSC     = 8'd128;
    localparam logic [7:0] PH_PAL_EVEN = 8'd96;
    localparam logic [7:0] PH_PAL_ODD  = 8'd160;

    // An amplitude code of 111 means "no modulation": chroma sits at midpoint.
    localparam logic [2:0] AMP_OFF     = 3'b111;
    localparam logic [5:0] CHROMA_MID  = 6'd32;

    // ------------------------------------------------------------------
    // Subcarrier accumulator and burst window state
    // ------------------------------------------------------------------
    logic [7:0]        r_acc;
    logic [BCNT_W-1:0] r_bcnt;
    logic [7:0]        r_burst_ph;

    logic              w_burst;
    logic [BCNT_W-1:0] w_burst_len;
    logic [7:0]        w_start_ph;

    // ------------------------------------------------------------------
    // Pipeline: stage A captures the resolved sample, stage B looks up the
    // sine value, stage C scales it and drives the outputs.
    // ------------------------------------------------------------------
    logic [5:0]        w_a_luma;
    logic [2:0]        w_a_amp;
    logic [7:0]        w_a_ph;
    logic              w_a_burst;
    logic [3:0]        w_a_idx;

    logic [5:0]        r_a_luma;
    logic [2:0]        r_a_amp;
    logic [3:0]        r_a_idx;
    logic              r_a_burst;

    logic signed [5:0] w_b_sine;

    logic [5:0]        r_b_luma;
    logic [2:0]        r_b_amp;
    logic signed [5:0] r_b_sine;
    logic              r_b_burst;

    logic signed [5:0] w_c_scaled;
    logic [5:0]        w_c_chroma;

    logic [5:0]        r_luma_out;
    logic [5:0]        r_chroma_out;
    logic              r_burst_active;

    // Free-running subcarrier phase; the 8-bit register wraps 240 -> 0 on
    // its own, and only reset brings it back to zero.
    always_ff @(posedge clk_col16x or posedge rst) begin
        // NOTE: every register here is written with <= so all flops sample
        // the pre-edge values of their neighbours; blocking = would leak
        // the new value into later statements within the same edge.
        if (rst) begin
            r_acc <= 8'd0;
        end else begin
            r_acc <= r_acc + ACC_STEP;
        end
    end

    // A burst is in progress while the down-counter is non-zero. The
    // standard and line parity are frozen at the start pulse so they
    // cannot disturb a burst already being emitted.
    assign w_burst     = (r_bcnt != '0);
    assign w_burst_len = is_pal ? BCNT_W'(PAL_BURST_CLKS) : BCNT_W'(NTSC_BURST_CLKS);
    assign w_start_ph  = !is_pal ? PH_NTSC : (oddline ? PH_PAL_ODD : PH_PAL_EVEN);

    // Burst window counter. Sync aborts the burst and masks start pulses.
    // A pulse during a burst reloads the full length from that pulse.
    always_ff @(posedge clk_col16x or posedge rst) begin
        if (rst) begin
            r_bcnt     <= '0;
            r_burst_ph <= 8'd0;
        end else if (sync) begin
            r_bcnt     <= '0;
        end else if (burst_start) begin
            r_bcnt     <= w_burst_len;
            r_burst_ph <= w_start_ph;
        end else if (w_burst) begin
            r_bcnt     <= r_bcnt - BCNT_W'(1);
        end
    end

    // Resolve the current sample with priority sync > burst > blank > video.
    always_comb begin
        // NOTE: defaults first, so every path assigns every output and no
        // latch is inferred when a branch leaves a signal untouched.
        w_a_luma  = luma_in;
        w_a_amp   = amplitude_in;
        w_a_ph    = phase_in;
        w_a_burst = 1'b0;
        if (sync) begin
            w_a_luma  = 6'd0;
            w_a_amp   = AMP_OFF;
        end else if (w_burst) begin
            w_a_luma  = BLANK_LEVEL;
            w_a_amp   = BURST_AMP;
            w_a_ph    = r_burst_ph;
            w_a_burst = 1'b1;
        end else if (blank) begin
            w_a_luma  = BLANK_LEVEL;
            w_a_amp   = AMP_OFF;
        end
    end

    // Table index is the top nibble of (accumulator + phase) modulo 256.
    assign w_a_idx = 4'((r_acc + w_a_ph) >> 4);

    // Stage A: capture the resolved sample together with its phase index.
    always_ff @(posedge clk_col16x or posedge rst) begin
        if (rst) begin
            r_a_luma  <= 6'd0;
            r_a_amp   <= AMP_OFF;
            r_a_idx   <= 4'd0;
            r_a_burst <= 1'b0;
        end else begin
            r_a_luma  <= w_a_luma;
            r_a_amp   <= w_a_amp;
            r_a_idx   <= w_a_idx;
            r_a_burst <= w_a_burst;
        end
    end

    // One subcarrier cycle of a signed sine, amplitude 31, 16 samples.
    always_comb begin
        // NOTE: this table is constant decode logic, not storage, so it has
        // no reset; only the pipeline flops around it are cleared.
        w_b_sine = 6'sd0;
        case (r_a_idx)
            4'd0:    w_b_sine =  6'sd0;
            4'd1:    w_b_sine =  6'sd12;
            4'd2:    w_b_sine =  6'sd22;
            4'd3:    w_b_sine =  6'sd29;
            4'd4:    w_b_sine =  6'sd31;
            4'd5:    w_b_sine =  6'sd29;
            4'd6:    w_b_sine =  6'sd22;
            4'd7:    w_b_sine =  6'sd12;
            4'd8:    w_b_sine =  6'sd0;
            4'd9:    w_b_sine = -6'sd12;
            4'd10:   w_b_sine = -6'sd22;
            4'd11:   w_b_sine = -6'sd29;
            4'd12:   w_b_sine = -6'sd31;
            4'd13:   w_b_sine = -6'sd29;
            4'd14:   w_b_sine = -6'sd22;
            4'd15:   w_b_sine = -6'sd12;
            default: w_b_sine =  6'sd0;
        endcase
    end

    // Stage B: hold the looked-up sine value alongside luma and amplitude.
    always_ff @(posedge clk_col16x or posedge rst) begin
        if (rst) begin
            r_b_luma  <= 6'd0;
            r_b_amp   <= AMP_OFF;
            r_b_sine  <= 6'sd0;
            r_b_burst <= 1'b0;
        end else begin
            r_b_luma  <= r_a_luma;
            r_b_amp   <= r_a_amp;
            r_b_sine  <= w_b_sine;
            r_b_burst <= r_a_burst;
        end
    end

    // The arithmetic shift floors toward minus infinity. Midpoint plus a
    // value in -31..31 stays within 1..63, so the 6-bit sum never wraps.
    assign w_c_scaled = r_b_sine >>> r_b_amp;
    assign w_c_chroma = (r_b_amp == AMP_OFF) ? CHROMA_MID
                                             : CHROMA_MID + $unsigned(w_c_scaled);

    // Stage C: output registers; reset presents sync-tip luma and flat chroma.
    always_ff @(posedge clk_col16x or posedge rst) begin
        if (rst) begin
            r_luma_out     <= 6'd0;
            r_chroma_out   <= CHROMA_MID;
            r_burst_active <= 1'b0;
        end else begin
            r_luma_out     <= r_b_luma;
            r_chroma_out   <= w_c_chroma;
            r_burst_active <= r_b_burst;
        end
    end

    assign luma_out     = r_luma_out;
    assign chroma_out   = r_chroma_out;
    assign burst_active = r_burst_active;

endmodule

// File: doc/chroma_mod.md
CHROMA_MOD -- requirements
Module: chroma_mod

Interface
REQ-001 SHALL have parameter BLANK_LEVEL, default 6'd18, luma code driven during blanking.
REQ-002 SHALL have parameter BURST_AMP, default 3'b010, amplitude code used during colour burst.
REQ-003 SHALL have parameter NTSC_BURST_CLKS, default 144, burst length in clocks for NTSC (9 subcarrier cycles).
REQ-004 SHALL have parameter PAL_BURST_CLKS, default 160, burst length in clocks for PAL (10 subcarrier cycles).
REQ-005 SHALL have port clk_col16x  in  1  sole clock, 16x colour subcarrier frequency.
REQ-006 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port luma_in  in  6  luma code from the upstream luma lookup.
REQ-008 SHALL have port amplitude_in  in  3  chroma amplitude code; 000 highest, 110 lowest, 111 no modulation.
REQ-009 SHALL have port phase_in  in  8  chroma phase offset, 256 units per 360 deg, already PAL-line-alternated upstream.
REQ-010 SHALL have port is_pal  in  1  1 = PAL burst rules, 0 = NTSC.
REQ-011 SHALL have port oddline  in  1  PAL line parity, used only for burst phase.
REQ-012 SHALL have port sync  in  1  sync tip active.
REQ-013 SHALL have port blank  in  1  blanking interval active.
REQ-014 SHALL have port burst_start  in  1  single-clock pulse starting the burst window.
REQ-015 SHALL have port luma_out  out  6  composite luma code to DAC.
REQ-016 SHALL have port chroma_out  out  6  modulated chroma, unsigned, midpoint 32.
REQ-017 SHALL have port burst_active  out  1  high while burst is being emitted, aligned with chroma_out.

Function
REQ-018 SHALL keep an 8-bit subcarrier accumulator acc, +16 every clock, free-running, wrapping 240->0; only rst clears it.
REQ-019 SHALL form sample index idx = (acc + ph)[7:4], ph = phase_in or burst phase, 8-bit addition modulo 256.
REQ-020 SHALL use 16-entry signed sine table S[idx] = 0,12,22,29,31,29,22,12,0,-12,-22,-29,-31,-29,-22,-12.
REQ-021 SHALL compute chroma = 32 + (S[idx] >>> amp) (arithmetic shift, floor); amp = 111 forces chroma = 32; no clamping (range 1..63).
REQ-022 SHALL pipeline two stages: inputs sampled at edge N (with acc value at N) appear on all outputs after edge N+2.
REQ-023 SHALL keep burst counter bcnt; burst_start (sync low) loads bcnt = burst length (PAL_BURST_CLKS if is_pal else NTSC_BURST_CLKS) and marks burst active.
REQ-024 SHALL decrement bcnt each clock while active; active ends on the clock bcnt reaches 0, giving exactly burst-length active cycles.
REQ-025 SHALL restart bcnt to full length on burst_start while burst is already active (no extension beyond one full length from latest pulse).
REQ-026 SHALL, during burst, use amp = BURST_AMP, ph = 128 (NTSC), ph = 96 (PAL, oddline=0) or 160 (PAL, oddline=1), and luma = BLANK_LEVEL.
REQ-027 SHALL apply per-sample priority sync > burst > blank > active video.
REQ-028 SHALL on sync: luma_out = 0, chroma_out = 32, burst aborted (bcnt = 0), burst_start ignored.
REQ-029 SHALL on blank without burst: luma_out = BLANK_LEVEL, chroma_out = 32.
REQ-030 SHALL in active video: luma_out = luma_in, chroma per REQ-021 with amp = amplitude_in, ph = phase_in.
REQ-031 SHALL sample is_pal and oddline at burst_start only; changes mid-burst do not affect the current burst.

Reset
REQ-032 SHALL on rst asynchronously force acc = 0, bcnt = 0, burst inactive, pipeline cleared, luma_out = 0, chroma_out = 32, burst_active = 0.
REQ-033 SHALL, after rst deassert, have acc = 16 after the first edge and outputs reflect real inputs from the third edge; rst mid-burst aborts burst with no resumption.

Verification
REQ-034 SHALL cover: rst, then active video phase_in=0 amplitude_in=000 luma_in=19 -> after 2-clock latency chroma_out cycles 32,44,54,61,63,61,54,44,32,20,10,3,1,3,10,20, luma_out=19.
REQ-035 SHALL cover: amplitude_in=111, any phase -> chroma_out constant 32; amplitude_in=010 phase_in=0 -> peak 39, trough 24.
REQ-036 SHALL cover: blank=1, is_pal=0, burst_start pulse -> burst_active high exactly 144 clocks, luma_out=18, chroma phase 180 deg (first sample at acc=0 equals 32, next 29).
REQ-037 SHALL cover: is_pal=1 with oddline 0 then 1 on successive bursts -> 160-clock bursts at 135 deg and 225 deg; toggling oddline mid-burst changes nothing.
REQ-038 SHALL cover: sync asserted at burst clock 50 -> burst_active low 2 clocks later, luma_out=0, chroma_out=32; second burst_start at clock 100 of a burst -> burst ends full length after that pulse.
REQ-039 SHALL cover: rst asserted mid-burst asynchronously -> outputs immediately luma 0, chroma 32, burst_active 0; acc restarts at 0.
